// File: rtl/feeder_msg_ctrl.sv
// feeder_msg_ctrl: cat-feeder sequencer driving the motor and the 3-bit LCD message code.
// Define FEEDER_SERVE_LIMIT_EN to cap servings per cat at MAX_SERVES between resets.
module feeder_msg_ctrl #(
    parameter int DEB_CYC   = 500000,
    parameter int DISP_CYC  = 100000000,
    parameter int SERVE_MAX = 500000000,
    parameter int CAT1_MIN  = 20,
    parameter int CAT1_MAX  = 45,
    parameter int CAT2_MIN  = 46,
    parameter int CAT2_MAX  = 80
`ifdef FEEDER_SERVE_LIMIT_EN
    , parameter int MAX_SERVES = 3
`endif
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       key_a,
    input  logic       key_b,
    input  logic       cat_present,
    input  logic [7:0] weight,
    input  logic       plate_full,
    output logic [2:0] mensaje,
    output logic       motor_on,
    output logic [1:0] cat_id
);
    typedef enum logic [2:0] {
        IDLE = 3'b000, CAT1 = 3'b001, CAT2 = 3'b010,
        WAIT_CAT = 3'b011, SERVE = 3'b100, FULL = 3'b101
    } state_t;
    localparam int DW = $clog2(DEB_CYC + 1);
    state_t state_q, state_d;
    logic [2:0] ka_q, kb_q;
    logic [1:0] cp_q, pf_q;
    logic [DW-1:0] deb_q, deb_d;
    logic cat_ok_q, cat_ok_d;
    logic clr_q, clr_d;
    logic [1:0] cat_id_q, cat_id_d;
    logic [29:0] tmr_q, tmr_d;
    logic ka_pulse, kb_pulse, is_c1, is_c2, disp_end, serve_end, capped;
    assign ka_pulse  = ka_q[1] & ~ka_q[2];
    assign kb_pulse  = kb_q[1] & ~kb_q[2];
    assign is_c1     = weight >= 8'(CAT1_MIN) && weight <= 8'(CAT1_MAX);
    assign is_c2     = weight >= 8'(CAT2_MIN) && weight <= 8'(CAT2_MAX);
    assign disp_end  = tmr_q == 30'(DISP_CYC - 1);
    assign serve_end = pf_q[1] || tmr_q == 30'(SERVE_MAX - 1);
    assign mensaje   = state_q;
    assign motor_on  = state_q == SERVE;
    assign cat_id    = cat_id_q;
`ifdef FEEDER_SERVE_LIMIT_EN
    localparam logic [1:0] MAXS = 2'(MAX_SERVES);
    logic [1:0] srv1_q, srv1_d, srv2_q, srv2_d;
    logic srv_entry;
    assign capped    = cat_id_q == 2'b10 ? srv2_q == MAXS : srv1_q == MAXS;
    assign srv_entry = state_d == SERVE && state_q != SERVE;
    always_comb begin
        srv1_d = kb_pulse ? 2'b00 : (srv_entry && cat_id_q == 2'b01 && srv1_q != MAXS) ? srv1_q + 2'b01 : srv1_q;
        srv2_d = kb_pulse ? 2'b00 : (srv_entry && cat_id_q == 2'b10 && srv2_q != MAXS) ? srv2_q + 2'b01 : srv2_q;
    end
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            srv1_q <= 2'b00;
            srv2_q <= 2'b00;
        end else begin
            srv1_q <= srv1_d;
            srv2_q <= srv2_d;
        end
    end
`else
    assign capped = 1'b0;
`endif
    // cat_ok flips only after the synced input has disagreed for DEB_CYC straight cycles
    always_comb begin
        deb_d    = (cp_q[1] == cat_ok_q || deb_q == DW'(DEB_CYC - 1)) ? '0 : deb_q + 1'b1;
        cat_ok_d = (cp_q[1] != cat_ok_q && deb_q == DW'(DEB_CYC - 1)) ? cp_q[1] : cat_ok_q;
    end
    always_comb begin
        state_d  = state_q;
        cat_id_d = cat_id_q;
        clr_d    = clr_q & cat_ok_q;
        case (state_q)
            IDLE:     if (ka_pulse) state_d = WAIT_CAT;
            WAIT_CAT: if (cat_ok_q && !clr_q) begin
                          state_d  = is_c1 ? CAT1 : is_c2 ? CAT2 : WAIT_CAT;
                          cat_id_d = is_c1 ? 2'b01 : is_c2 ? 2'b10 : 2'b00;
                      end
            CAT1, CAT2: if (disp_end) state_d = capped ? FULL : SERVE;
            SERVE:    if (serve_end) state_d = FULL;
            FULL:     if (disp_end) begin
                          state_d  = WAIT_CAT;
                          cat_id_d = 2'b00;
                          clr_d    = 1'b1;
                      end
            default:  state_d = IDLE;
        endcase
        if (kb_pulse) begin
            state_d  = IDLE;
            cat_id_d = 2'b00;
            clr_d    = 1'b0;
        end
        tmr_d = (state_d != state_q || state_q == IDLE || state_q == WAIT_CAT) ? '0 : tmr_q + 1'b1;
    end
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            ka_q     <= '0;
            kb_q     <= '0;
            cp_q     <= '0;
            pf_q     <= '0;
            deb_q    <= '0;
            cat_ok_q <= 1'b0;
            clr_q    <= 1'b0;
            cat_id_q <= 2'b00;
            tmr_q    <= '0;
            state_q  <= IDLE;
        end else begin
            ka_q     <= {ka_q[1:0], key_a};
            kb_q     <= {kb_q[1:0], key_b};
            cp_q     <= {cp_q[0], cat_present};
            pf_q     <= {pf_q[0], plate_full};
            deb_q    <= deb_d;
            cat_ok_q <= cat_ok_d;
            clr_q    <= clr_d;
            cat_id_q <= cat_id_d;
            tmr_q    <= tmr_d;
            state_q  <= state_d;
        end
    end
endmodule

// File: tb/tb_feeder_msg_ctrl.sv
// tb_feeder_msg_ctrl: randomized visits checked against a latency/classification model of the feeder.
module tb_feeder_msg_ctrl;
    localparam int DEB = 4, DISP = 8, SMAX = 20;
    logic iCLK = 0, iRST_N = 0, key_a = 0, key_b = 0, cat_present = 0, plate_full = 0;
    logic [7:0] weight = 0;
    logic [2:0] mensaje;
    logic motor_on;
    logic [1:0] cat_id;
    int n_chk = 0, n_pass = 0;
    int served [3];

    feeder_msg_ctrl #(.DEB_CYC(DEB), .DISP_CYC(DISP), .SERVE_MAX(SMAX)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .key_a(key_a), .key_b(key_b),
        .cat_present(cat_present), .weight(weight), .plate_full(plate_full),
        .mensaje(mensaje), .motor_on(motor_on), .cat_id(cat_id));

    always #5 iCLK = ~iCLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    function automatic int classify(input int w);
        return (w >= 20 && w <= 45) ? 1 : (w >= 46 && w <= 80) ? 2 : 0;
    endfunction

    task automatic clear_served();
        for (int i = 0; i < 3; i++) served[i] = 0;
    endtask

    task automatic clear_cat();
        cat_present = 0;
        tick(DEB + 4);
    endtask

    task automatic start();
        key_a = 1;
        tick(2);
        chk("idle_hold", mensaje, 0);
        tick(1);
        chk("wait_entry", mensaje, 3);
        chk("wait_motor", motor_on, 0);
        chk("wait_id", cat_id, 0);
        tick(2);
        key_a = 0;
        tick(3);
    endtask

    task automatic visit(input int w, input bit pf_early, input int j);
        int c, cnt;
        bit capped;
        c = classify(w);
        weight = 8'(w);
        cat_present = 1;
        tick(DEB + 2);
        chk("pre_class", mensaje, 3);
        tick(1);
        if (c == 0) begin
            chk("noclass_msg", mensaje, 3);
            chk("noclass_id", cat_id, 0);
            tick(5);
            chk("noclass_hold", mensaje, 3);
            clear_cat();
            return;
        end
        chk("class_msg", mensaje, c);
        chk("class_id", cat_id, c);
        key_a = 1;
        if (pf_early) plate_full = 1;
        tick(1);
        key_a = 0;
        tick(DISP - 2);
        chk("dwell_msg", mensaje, c);
        chk("dwell_motor", motor_on, 0);
        tick(1);
`ifdef FEEDER_SERVE_LIMIT_EN
        capped = served[c] == 3;
`else
        capped = 0;
`endif
        if (capped) begin
            chk("capped_full", mensaje, 5);
            chk("capped_motor", motor_on, 0);
        end else begin
            chk("serve_msg", mensaje, 4);
            if (served[c] < 3) served[c]++;
            cnt = 0;
            for (int k = 0; k < 60 && motor_on; k++) begin
                cnt++;
                if (cnt == j && !pf_early) plate_full = 1;
                tick(1);
            end
            chk("motor_cycles", cnt, pf_early ? 1 : (j + 2 < SMAX ? j + 2 : SMAX));
            chk("full_msg", mensaje, 5);
        end
        plate_full = 0;
        tick(DISP - 1);
        chk("full_dwell", mensaje, 5);
        tick(1);
        chk("back_wait", mensaje, 3);
        chk("id_clear", cat_id, 0);
        tick(DEB + 3);
        chk("no_reserve", mensaje, 3);
        clear_cat();
    endtask

    task automatic reach_serve();
        weight = 8'd30;
        cat_present = 1;
        for (int k = 0; k < 40 && mensaje != 3'b100; k++) tick(1);
        chk("reach_serve", mensaje, 4);
        tick(2);
    endtask

    initial begin
        int wl [12] = '{30, 60, 90, 10, 20, 45, 46, 80, 81, 19, 0, 255};
        clear_served();
        tick(2);
        chk("rst_msg", mensaje, 0);
        chk("rst_motor", motor_on, 0);
        chk("rst_id", cat_id, 0);
        iRST_N = 1;
        tick(2);
        start();
        weight = 8'd30;
        cat_present = 1;
        tick(2);
        cat_present = 0;
        tick(10);
        chk("glitch_msg", mensaje, 3);
        chk("glitch_id", cat_id, 0);
        reach_serve();
        key_a = 1;
        key_b = 1;
        tick(1);
        key_a = 0;
        key_b = 0;
        tick(1);
        chk("kb_pending", mensaje, 4);
        tick(1);
        chk("kb_idle", mensaje, 0);
        chk("kb_motor", motor_on, 0);
        chk("kb_id", cat_id, 0);
        tick(3);
        chk("kb_stay_idle", mensaje, 0);
        clear_served();
        clear_cat();
        start();
        reach_serve();
        #2 iRST_N = 0;
        #1 chk("arst_motor", motor_on, 0);
        chk("arst_msg", mensaje, 0);
        tick(1);
        iRST_N = 1;
        clear_served();
        clear_cat();
        start();
        foreach (wl[i]) visit(wl[i], i == 7, 3 + i);
        repeat (10) visit($urandom_range(0, 100), $urandom_range(0, 3) == 0, $urandom_range(1, 22));
        key_b = 1;
        tick(3);
        key_b = 0;
        chk("kb_wait_idle", mensaje, 0);
        clear_served();
        tick(2);
        start();
        visit(30, 0, 5);
        visit(35, 0, 25);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
